// File: rtl/window_col3_g0.sv
// window_col3_g0: horizontal 3-tap window over a LEN-row column stream, zero-padded at row edges
// Ports: i_sclk clock; i_vsync sync reset / frame start; i_valid, i_reuse, i_tdata input column word;
//        o_valid, o_reuse, o_sol, o_eol, o_tdata {left,centre,right} window; o_err sticky overrun.
module window_col3_g0 #(
    parameter int WIDTH   = 27,
    parameter int LEN     = 3,
    parameter int SIZE    = 56,
    parameter int CHANNEL = 64
) (
    input  logic                     i_sclk,
    input  logic                     i_vsync,
    input  logic                     i_valid,
    input  logic                     i_reuse,
    input  logic [LEN*WIDTH-1:0]     i_tdata,
    output logic                     o_valid,
    output logic                     o_reuse,
    output logic                     o_sol,
    output logic                     o_eol,
    output logic [3*LEN*WIDTH-1:0]   o_tdata,
    output logic                     o_err
);
    localparam int DW = LEN * WIDTH;
    localparam int XW = $clog2(SIZE + 1);
    localparam int CW = $clog2(CHANNEL);
    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
    logic [DW:0]       r_bank [3][CHANNEL];
    logic [XW-1:0]     r_x_in;
    logic [CW-1:0]     r_c_in, r_c_fl;
    logic [1:0]        r_wp;
    state_t            r_state;
    logic              r_valid, r_reuse, r_sol, r_eol, r_err;
    logic [3*DW-1:0]   r_tdata;
    logic [1:0]        w_p1, w_p2;
    logic [CW-1:0]     w_c;
    logic [DW:0]       w_left, w_ctr;
    logic [DW-1:0]     w_lft;
    logic              w_c_last, w_x_last, w_fl_last;
    // r_wp is x_in mod 3; the centre bank is one behind it and the left bank two behind (== one ahead)
    assign w_p1      = (r_wp == 2'd0) ? 2'd2 : r_wp - 2'd1;
    assign w_p2      = (r_wp == 2'd2) ? 2'd0 : r_wp + 2'd1;
    assign w_c       = (r_state == FLUSH) ? r_c_fl : r_c_in;
    assign w_left    = r_bank[w_p2][w_c];
    assign w_ctr     = r_bank[w_p1][w_c];
    // centre x=0 has no left neighbour: pad with zero instead of reading a stale bank
    assign w_lft     = (r_state == RUN && r_x_in == XW'(1)) ? '0 : w_left[DW-1:0];
    assign w_c_last  = r_c_in == CW'(CHANNEL - 1);
    assign w_x_last  = r_x_in == XW'(SIZE - 1);
    assign w_fl_last = r_c_fl == CW'(CHANNEL - 1);
    always_ff @(posedge i_sclk) begin
        if (!i_vsync && i_valid && r_state != FLUSH)
            r_bank[r_wp][r_c_in] <= {i_reuse, i_tdata};
    end
    always_ff @(posedge i_sclk) begin
        if (i_vsync) begin
            r_x_in  <= '0;
            r_c_in  <= '0;
            r_c_fl  <= '0;
            r_wp    <= '0;
            r_state <= FILL;
            r_valid <= 1'b0;
            r_reuse <= 1'b0;
            r_sol   <= 1'b0;
            r_eol   <= 1'b0;
            r_err   <= 1'b0;
            r_tdata <= '0;
        end else begin
            r_valid <= 1'b0;
            r_sol   <= 1'b0;
            r_eol   <= 1'b0;
            if (r_state == FLUSH) begin
                // last pixel of the row still needs its windows; right neighbour is the zero pad
                r_valid <= 1'b1;
                r_tdata <= {w_left[DW-1:0], w_ctr[DW-1:0], {DW{1'b0}}};
                r_reuse <= w_ctr[DW];
                r_eol   <= w_fl_last;
                r_c_fl  <= r_c_fl + 1'b1;
                if (i_valid)
                    r_err <= 1'b1;
                if (w_fl_last) begin
                    r_x_in  <= '0;
                    r_c_in  <= '0;
                    r_c_fl  <= '0;
                    r_wp    <= '0;
                    r_state <= FILL;
                end
            end else if (i_valid) begin
                r_c_in <= w_c_last ? '0 : r_c_in + 1'b1;
                if (r_state == RUN) begin
                    r_valid <= 1'b1;
                    r_tdata <= {w_lft, w_ctr[DW-1:0], i_tdata};
                    r_reuse <= w_ctr[DW];
                    r_sol   <= r_x_in == XW'(1) && r_c_in == '0;
                end
                if (w_c_last) begin
                    r_x_in  <= r_x_in + 1'b1;
                    r_wp    <= w_p2;
                    r_state <= w_x_last ? FLUSH : RUN;
                end
            end
        end
    end
    assign o_valid = r_valid;
    assign o_reuse = r_reuse;
    assign o_sol   = r_sol;
    assign o_eol   = r_eol;
    assign o_tdata = r_tdata;
    assign o_err   = r_err;
endmodule
